// File: rtl/product_bcd_conv_if.sv
// Product / BCD handshake bundle between the multiplier, the BCD converter and the display path.
// master = producer side (multiplier), slave = converter side.
interface product_bcd_conv_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
);
    logic [WIDTH-1:0]    Product;
    logic                Product_Valid;
    logic [4*DIGITS-1:0] BCD;
    logic                BCD_Valid;
    logic                Busy;
    logic                Overrun;

    modport master (
        output Product,
        output Product_Valid,
        input  BCD,
        input  BCD_Valid,
        input  Busy,
        input  Overrun
    );

    modport slave (
        input  Product,
        input  Product_Valid,
        output BCD,
        output BCD_Valid,
        output Busy,
        output Overrun
    );
endinterface

// File: rtl/product_bcd_conv.sv
// Sequential double-dabble converter: one shift-add-3 iteration per clock, WIDTH iterations per product.
// BCD only changes on completion; BCD_Valid pulses for one cycle alongside it.
module product_bcd_conv #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic              CLK,
    input  logic              RST,
    product_bcd_conv_if.slave bus
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   work_q, work_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               bcd_valid_q, bcd_valid_d;
    logic               overrun_q, overrun_d;

    logic [BCD_W-1:0]   work_adj;
    logic [BCD_W-1:0]   work_shift;
    logic [WIDTH-1:0]   bin_shift;

    // Digits are <=9 after correction, so +3 never carries into the next digit.
    function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] w);
        logic [BCD_W-1:0] r;
        r = w;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (w[4*d +: 4] >= 4'd5)
                r[4*d +: 4] = w[4*d +: 4] + 4'd3;
        end
        return r;
    endfunction

    always_comb begin
        work_adj = add3_digits(work_q);
        {work_shift, bin_shift} = {work_adj, bin_q} << 1;
    end

    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        work_d      = work_q;
        cnt_d       = cnt_q;
        bcd_d       = bcd_q;
        bcd_valid_d = 1'b0;
        overrun_d   = overrun_q;

        unique case (state_q)
            IDLE: begin
                if (bus.Product_Valid) begin
                    state_d = SHIFT;
                    bin_d   = bus.Product;
                    work_d  = '0;
                    cnt_d   = '0;
                end
            end

            SHIFT: begin
                work_d = work_shift;
                bin_d  = bin_shift;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    bcd_d       = work_shift;
                    bcd_valid_d = 1'b1;
                    // A product arriving on the final edge starts the next conversion back-to-back.
                    if (bus.Product_Valid) begin
                        bin_d  = bus.Product;
                        work_d = '0;
                        cnt_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (bus.Product_Valid) begin
                    overrun_d = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q     <= IDLE;
            bin_q       <= '0;
            work_q      <= '0;
            cnt_q       <= '0;
            bcd_q       <= '0;
            bcd_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            bcd_q       <= bcd_d;
            bcd_valid_q <= bcd_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.BCD       = bcd_q;
    assign bus.BCD_Valid = bcd_valid_q;
    assign bus.Busy      = (state_q == SHIFT);
    assign bus.Overrun   = overrun_q;

endmodule
